// File: rtl/trace_pkg.sv
// -----------------------------------------------------------------------------
// trace_pkg
// Shared types and widths for the pipeline trace recorder.
//   trace_rec_t : one retire record as seen by the trace printer
//   stage_tag_t : per-stage shadow tag carried alongside ID/EX/MEM/WB
//   sat_inc     : saturating increment for the per-instruction stall count
// -----------------------------------------------------------------------------
package trace_pkg;

    localparam int ID_W     = 8;   // sequence ID width (wraps)
    localparam int CYC_W    = 16;  // free-running cycle counter width (wraps)
    localparam int STL_W    = 3;   // stall count width (saturates)
    localparam int PC_W     = 16;
    localparam int INSTR_W  = 16;
    localparam int TR_DEPTH = 8;   // default retire FIFO depth

    typedef struct packed {
        logic [ID_W-1:0]    id;
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic [CYC_W-1:0]   fcyc;
        logic [CYC_W-1:0]   wcyc;
        logic [STL_W-1:0]   stalls;
    } trace_rec_t;

    typedef struct packed {
        logic               valid;
        logic [ID_W-1:0]    id;
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic [CYC_W-1:0]   fcyc;
        logic [STL_W-1:0]   stalls;
    } stage_tag_t;

    // Stall count sticks at all-ones rather than wrapping back to a small value.
    function automatic logic [STL_W-1:0] sat_inc(input logic [STL_W-1:0] v);
        return (v == '1) ? v : v + STL_W'(1);
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// -----------------------------------------------------------------------------
// trace_fifo
// First-word-fall-through synchronous FIFO for retire records.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   i_push/i_din : write request and data (dropped when full and not popping)
//   o_valid      : head entry present
//   i_ready      : consumer takes the head when o_valid & i_ready
//   o_dout       : head entry (don't-care when o_valid=0)
//   o_overflow   : sticky, set when a push was dropped; cleared only by reset
// -----------------------------------------------------------------------------
module trace_fifo #(
    parameter int  DEPTH = 8,
    parameter type T     = logic
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  T     i_din,
    output logic o_valid,
    input  logic i_ready,
    output T     o_dout,
    output logic o_overflow
);

    localparam int AW = $clog2(DEPTH);

    T r_mem [DEPTH];

    // Pointers carry one extra bit so full and empty are distinguishable
    // when the index bits match.
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic        r_overflow;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_wr;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop   = !w_empty && i_ready;
    // A pop in the same cycle frees the head slot, so a push on full still
    // lands: it overwrites the slot being read out at this edge.
    assign w_wr    = i_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr)
                r_wptr <= r_wptr + (AW+1)'(1);
            if (w_pop)
                r_rptr <= r_rptr + (AW+1)'(1);
            if (i_push && w_full && !w_pop)
                r_overflow <= 1'b1;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wptr[AW-1:0]] <= i_din;
    end

    assign o_valid    = !w_empty;
    assign o_dout     = r_mem[r_rptr[AW-1:0]];
    assign o_overflow = r_overflow;

endmodule

// File: rtl/pipeline_trace_recorder.sv
// -----------------------------------------------------------------------------
// pipeline_trace_recorder
// Producer side of the per-instruction pipeline trace. Tags each fetched
// instruction with a sequence ID and its ID-acceptance cycle, carries the tag
// through ID/EX/MEM/WB shadow registers following the hazard unit's stall and
// flush, and on write-back pushes one retire record into a FIFO drained by the
// trace printer. Purely an observer; it never drives the core.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   if_pc, if_instr     : instruction in fetch this cycle
//   stall               : PC and IF/ID hold (wins over flush)
//   flush               : squash the instruction being fetched
//   rec_valid/rec_ready : FWFT handshake to the trace printer
//   rec_id .. rec_stalls: head record fields (don't-care when rec_valid=0)
//   overflow            : sticky, a retire record was dropped on full FIFO
// -----------------------------------------------------------------------------
module pipeline_trace_recorder
    import trace_pkg::*;
#(
    parameter int DEPTH = TR_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PC_W-1:0]    if_pc,
    input  logic [INSTR_W-1:0] if_instr,
    input  logic               stall,
    input  logic               flush,
    output logic               rec_valid,
    input  logic               rec_ready,
    output logic [ID_W-1:0]    rec_id,
    output logic [PC_W-1:0]    rec_pc,
    output logic [INSTR_W-1:0] rec_instr,
    output logic [CYC_W-1:0]   rec_fcyc,
    output logic [CYC_W-1:0]   rec_wcyc,
    output logic [STL_W-1:0]   rec_stalls,
    output logic               overflow
);

    logic [CYC_W-1:0] r_cyc;
    logic [ID_W-1:0]  r_next_id;

    stage_tag_t r_id_s;
    stage_tag_t r_ex_s;
    stage_tag_t r_mem_s;
    stage_tag_t r_wb_s;

    trace_rec_t w_rec;
    trace_rec_t w_head;
    logic       w_push;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc     <= '0;
            r_next_id <= '0;
            r_id_s    <= '0;
            r_ex_s    <= '0;
            r_mem_s   <= '0;
            r_wb_s    <= '0;
        end else begin
            r_cyc <= r_cyc + CYC_W'(1);

            if (stall) begin
                // Decode holds its instruction and counts the stall; a bubble
                // goes down the pipe. A simultaneous flush is ignored.
                r_id_s.stalls <= sat_inc(r_id_s.stalls);
                r_ex_s        <= '0;
            end else begin
                // The ID is consumed even for a squashed fetch, so flushes
                // show up as gaps in the retired ID stream.
                r_id_s <= '{valid:  !flush,
                            id:     r_next_id,
                            pc:     if_pc,
                            instr:  if_instr,
                            fcyc:   r_cyc,
                            stalls: '0};
                r_ex_s    <= r_id_s;
                r_next_id <= r_next_id + ID_W'(1);
            end

            r_mem_s <= r_ex_s;
            r_wb_s  <= r_mem_s;
        end
    end

    // Write-back stamp is the current (pre-increment) cycle count.
    assign w_push = r_wb_s.valid;
    assign w_rec  = '{id:     r_wb_s.id,
                      pc:     r_wb_s.pc,
                      instr:  r_wb_s.instr,
                      fcyc:   r_wb_s.fcyc,
                      wcyc:   r_cyc,
                      stalls: r_wb_s.stalls};

    trace_fifo #(
        .DEPTH (DEPTH),
        .T     (trace_rec_t)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_din      (w_rec),
        .o_valid    (rec_valid),
        .i_ready    (rec_ready),
        .o_dout     (w_head),
        .o_overflow (overflow)
    );

    assign rec_id     = w_head.id;
    assign rec_pc     = w_head.pc;
    assign rec_instr  = w_head.instr;
    assign rec_fcyc   = w_head.fcyc;
    assign rec_wcyc   = w_head.wcyc;
    assign rec_stalls = w_head.stalls;

endmodule

// File: tb/tb_pipeline_trace_recorder.sv
// Directed bench with a retire-record scoreboard. The stimulus side keeps a
// one-entry model of the decode slot; when an instruction leaves decode its
// expected record (wcyc = fcyc + 4 + stall cycles) is queued, and a monitor
// pops and compares on every accepted handshake.
module tb_pipeline_trace_recorder;
    import trace_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [PC_W-1:0]    if_pc = '0;
    logic [INSTR_W-1:0] if_instr = '0;
    logic               stall = 1'b0;
    logic               flush = 1'b0;
    logic               rec_ready = 1'b0;
    logic               rec_valid;
    logic [ID_W-1:0]    rec_id;
    logic [PC_W-1:0]    rec_pc;
    logic [INSTR_W-1:0] rec_instr;
    logic [CYC_W-1:0]   rec_fcyc;
    logic [CYC_W-1:0]   rec_wcyc;
    logic [STL_W-1:0]   rec_stalls;
    logic               overflow;

    always #5 clk = ~clk;

    pipeline_trace_recorder #(.DEPTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_pc      (if_pc),
        .if_instr   (if_instr),
        .stall      (stall),
        .flush      (flush),
        .rec_valid  (rec_valid),
        .rec_ready  (rec_ready),
        .rec_id     (rec_id),
        .rec_pc     (rec_pc),
        .rec_instr  (rec_instr),
        .rec_fcyc   (rec_fcyc),
        .rec_wcyc   (rec_wcyc),
        .rec_stalls (rec_stalls),
        .overflow   (overflow)
    );

    int n_cmp = 0;
    int n_err = 0;

    trace_rec_t exp_q[$];
    trace_rec_t m_e;

    // decode-slot model
    logic             d_v = 1'b0;
    logic [ID_W-1:0]  d_id = '0;
    logic [15:0]      d_pc = '0;
    logic [15:0]      d_ins = '0;
    logic [15:0]      d_fcyc = '0;
    logic [STL_W-1:0] d_st = '0;
    int               d_ncyc = 0;
    logic [ID_W-1:0]  m_id = '0;
    logic [15:0]      m_cyc = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, update the model, then cross the sampling edge.
    task automatic step(input logic s, input logic f, input logic [15:0] pc);
        stall    = s;
        flush    = f;
        if_pc    = pc;
        if_instr = pc ^ 16'hC3A5;
        if (s) begin
            if (d_st != 3'd7) d_st = d_st + 3'd1;
            d_ncyc++;
        end else begin
            if (d_v)
                exp_q.push_back('{id: d_id, pc: d_pc, instr: d_ins, fcyc: d_fcyc,
                                  wcyc: d_fcyc + 16'd4 + 16'(d_ncyc), stalls: d_st});
            d_v    = !f;
            d_id   = m_id;
            d_pc   = pc;
            d_ins  = pc ^ 16'hC3A5;
            d_fcyc = m_cyc;
            d_st   = '0;
            d_ncyc = 0;
            m_id   = m_id + 8'd1;
        end
        @(posedge clk);
        #1;
        m_cyc = m_cyc + 16'd1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_rec_valid", {31'd0, rec_valid}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        rst = 1'b0;
        exp_q.delete();
        d_v    = 1'b0;
        d_st   = '0;
        d_ncyc = 0;
        m_id   = '0;
        m_cyc  = '0;
    endtask

    // Push squashed fetches until every expected record has been consumed,
    // then confirm nothing further comes out.
    task automatic drain(input string tag);
        int k = 0;
        while ((exp_q.size() != 0 || d_v) && k < 40) begin
            step(1'b0, 1'b1, 16'hFFFE);
            k++;
        end
        chk(tag, exp_q.size(), 32'd0);
        repeat (6) step(1'b0, 1'b1, 16'hFFFE);
        chk({tag, "_idle"}, {31'd0, rec_valid}, 32'd0);
    endtask

    // Scoreboard monitor: sample half a cycle away from the active edge.
    always @(negedge clk) begin
        if (!rst && rec_valid && rec_ready) begin
            chk("rec_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (exp_q.size() > 0) begin
                m_e = exp_q.pop_front();
                chk("rec_id",     {24'd0, rec_id},     {24'd0, m_e.id});
                chk("rec_pc",     {16'd0, rec_pc},     {16'd0, m_e.pc});
                chk("rec_instr",  {16'd0, rec_instr},  {16'd0, m_e.instr});
                chk("rec_fcyc",   {16'd0, rec_fcyc},   {16'd0, m_e.fcyc});
                chk("rec_wcyc",   {16'd0, rec_wcyc},   {16'd0, m_e.wcyc});
                chk("rec_stalls", {29'd0, rec_stalls}, {29'd0, m_e.stalls});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout n_cmp=%0d", n_cmp);
        $fatal(1, "timeout");
    end

    initial begin
        // 1: six plain fetches, first record stamped at cycle 4
        do_reset();
        rec_ready = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 16'(2 * i));
        drain("t1_drain");

        // 2: two stall cycles while ID 3 sits in decode
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'(2 * i));
        step(1'b1, 1'b0, 16'd8);
        step(1'b1, 1'b0, 16'd8);
        step(1'b0, 1'b0, 16'd8);
        step(1'b0, 1'b0, 16'd10);
        drain("t2_drain");

        // 3: ID 2 flushed at fetch
        do_reset();
        step(1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 16'h0002);
        step(1'b0, 1'b1, 16'h0004);
        step(1'b0, 1'b0, 16'h0006);
        step(1'b0, 1'b0, 16'h0008);
        drain("t3_drain");

        // 4: stall and flush together act as a stall
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'(16'h100 + 2 * i));
        step(1'b1, 1'b1, 16'h0106);
        step(1'b0, 1'b0, 16'h0106);
        drain("t4_drain");

        // 4b: long stall saturates the stall count but not the latency
        do_reset();
        step(1'b0, 1'b0, 16'h0200);
        repeat (9) step(1'b1, 1'b0, 16'h0202);
        step(1'b0, 1'b0, 16'h0202);
        drain("t4b_drain");

        // 5: backpressure, ten retirements into eight entries
        do_reset();
        rec_ready = 1'b0;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 16'(16'h300 + 2 * i));
        repeat (6) step(1'b0, 1'b1, 16'hFFFE);
        chk("t5_overflow", {31'd0, overflow}, 32'd1);
        chk("t5_valid", {31'd0, rec_valid}, 32'd1);
        chk("t5_queued", exp_q.size(), 32'd10);
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        chk("t5_head_id", {24'd0, rec_id}, {24'd0, exp_q[0].id});
        step(1'b0, 1'b1, 16'hFFFE);
        step(1'b0, 1'b1, 16'hFFFE);
        chk("t5_hold_id", {24'd0, rec_id}, {24'd0, exp_q[0].id});
        chk("t5_hold_wcyc", {16'd0, rec_wcyc}, {16'd0, exp_q[0].wcyc});
        rec_ready = 1'b1;
        drain("t5_drain");
        chk("t5_overflow_sticky", {31'd0, overflow}, 32'd1);

        // 6: reset with instructions in flight and FIFO non-empty
        do_reset();
        rec_ready = 1'b0;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 16'(16'h400 + 2 * i));
        chk("t6_pre_valid", {31'd0, rec_valid}, 32'd1);
        do_reset();
        rec_ready = 1'b1;
        step(1'b0, 1'b0, 16'h0040);
        drain("t6_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
